ps2_key_event_decoder: RTL and testbench
========================================

PS2_KEY_EVENT_DECODER -- requirements
Module: ps2_key_event_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event-queue entries; power of two, at least 2.
REQ-002 Parameter INIT_REQUIRED, default 1; 1 means decoding starts only after a 0xAA self-test byte, 0 means decoding starts at reset release.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  received PS/2 byte.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 evt_valid  output  1  event queue non-empty.
REQ-008 evt_ready  input  1  consumer pops the head event when evt_valid=1.
REQ-009 evt_code  output  9  head event code, {extended, scan[7:0]}.
REQ-010 evt_make  output  1  head event type: 1=make, 0=break.
REQ-011 key_down  output  512  pressed-key bitmap, indexed by 9-bit code.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-013 overflow  output  1  sticky flag: an event was dropped.
REQ-014 clr_overflow  input  1  clears overflow.

Function
REQ-015 The parser FSM SHALL have states WAIT_INIT, IDLE, EXT (after 0xE0), BRK (after 0xF0) and EXT_BRK (after 0xE0 then 0xF0); it advances only on rx_valid.
REQ-016 Transitions:
- WAIT_INIT: 0xAA -> IDLE; any other byte is ignored.
- IDLE: 0xE0 -> EXT; 0xF0 -> BRK.
- EXT: 0xF0 -> EXT_BRK.
- A data byte in IDLE/EXT/BRK/EXT_BRK returns the FSM to IDLE.
REQ-017 Data byte b SHALL produce these events: IDLE make {0,b}; EXT make {1,b}; BRK break {0,b}; EXT_BRK break {1,b}.
REQ-018 In IDLE, bytes 0xFA, 0xFE, 0xEE, 0x00, 0xFF and 0xE1 SHALL be ignored with no event; 0xAA SHALL clear key_down and leave the FSM in IDLE.
REQ-019 In EXT, BRK and EXT_BRK, a repeated 0xE0 or 0xF0 SHALL be treated as a protocol error: return to IDLE, no event.
REQ-020 On each event, key_down[code] SHALL be set (make) or cleared (break) at the same clock edge that samples rx_valid; the update is visible one cycle later.
REQ-021 Event queue SHALL be first-word-fall-through: an event pushed into an empty queue raises evt_valid on the next cycle.
REQ-022 A pop occurs on evt_valid and evt_ready in the same cycle; evt_ready with evt_valid=0 SHALL have no effect.
REQ-023 Push while full with no pop SHALL drop the event and set overflow; key_down is still updated.
REQ-024 Push and pop in the same cycle SHALL both succeed, including when full; fifo_level is unchanged.
REQ-025 Queue pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 If clr_overflow and a new drop occur in the same cycle, overflow SHALL remain 1.

Reset
REQ-027 While rst=1:
- FSM = WAIT_INIT if INIT_REQUIRED=1, else IDLE.
- key_down, fifo_level, evt_valid and overflow = 0.
- evt_code = 0, evt_make = 0.
REQ-028 Asserting rst mid-sequence (for example after 0xE0) SHALL discard the pending prefix and all queued events.

Configuration
REQ-029 With PS2_TYPEMATIC_FILTER_EN defined, a make event whose key_down bit is already 1 (auto-repeat) SHALL NOT be queued; key_down is unchanged.
REQ-030 Without PS2_TYPEMATIC_FILTER_EN, every make event SHALL be queued.
REQ-031 Break events SHALL always be queued, including for keys not currently down.

Structure
REQ-032 Shared package ps2_pkg SHALL hold:
- byte constants PS2_EXTEND=0xE0, PS2_BREAK=0xF0, PS2_BAT_OK=0xAA, PS2_PAUSE=0xE1;
- the parser state enum;
- the 10-bit event type {make, code[8:0]}.
REQ-033 The queue SHALL be the sub-module ps2_evt_fifo, parameterised by width and depth, and it owns overflow-free push/pop and level logic.

Verification
REQ-034 INIT_REQUIRED=1; send 0x1C before 0xAA -> no event; send 0xAA then 0x1C -> event make 0x01C, key_down[0x01C]=1.
REQ-035 Send 0xE0,0x75 then 0xE0,0xF0,0x75 -> events make 0x175 then break 0x175; key_down[0x175] ends 0.
REQ-036 Send 0x1C three times with the filter macro defined -> 1 event; without the macro -> 3 events.
REQ-037 FIFO_DEPTH=4, evt_ready=0, send 5 makes -> fifo_level=4, overflow=1, 5th code absent from the queue but set in key_down; clr_overflow -> overflow=0.
REQ-038 Full queue; push and pop in the same cycle -> fifo_level stays 4, head advances; then send 0xE0 and assert rst -> all outputs 0, next 0x75 (after 0xAA) gives make 0x075.

Source files
------------

// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared PS/2 decoder definitions: protocol byte constants, parser states and the queued event type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXTEND = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic       make;
    logic [8:0] code;
  } ps2_evt_t;

  // Bytes that never yield an event when seen with no prefix pending.
  function automatic logic idle_no_event(input logic [7:0] b);
    return (b == PS2_EXTEND) || (b == PS2_BREAK) || (b == PS2_BAT_OK) ||
           (b == PS2_PAUSE)  || (b == PS2_ACK)   || (b == PS2_RESEND) ||
           (b == PS2_ECHO)   || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-in / event-out handshake bundle of the PS/2 key event decoder.
interface ps2_key_event_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_code;
  logic       evt_make;

  modport master (
    output rx_data, rx_valid, evt_ready,
    input  evt_valid, evt_code, evt_make
  );

  modport slave (
    input  rx_data, rx_valid, evt_ready,
    output evt_valid, evt_code, evt_make
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event queue; a push into a full queue is accepted only alongside a pop.
module ps2_evt_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  // Head reads as zero while empty so nothing stale leaks onto the outputs.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 decoder: make/break events into a queue plus a pressed-key bitmap.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses queuing of auto-repeat makes.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned INIT_REQUIRED = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  ps2_key_event_decoder_if.slave       bus,
  output logic [511:0]                 key_down,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  input  logic                         clr_overflow
);
  localparam ps2_state_t RESET_STATE = (INIT_REQUIRED != 0) ? WAIT_INIT : IDLE;

  ps2_state_t state;
  ps2_evt_t   evt_d;
  ps2_evt_t   head;
  logic       evt_fire;
  logic       push;
  logic       pop;
  logic       empty;
  logic       full;
  logic       drop;

  // Event implied by the incoming byte in the current parser state.
  always_comb begin
    evt_fire = 1'b0;
    evt_d    = '0;
    if (bus.rx_valid) begin
      case (state)
        IDLE: begin
          evt_fire = !idle_no_event(bus.rx_data);
          evt_d    = '{make: 1'b1, code: {1'b0, bus.rx_data}};
        end
        EXT: begin
          evt_fire = (bus.rx_data != PS2_EXTEND) && (bus.rx_data != PS2_BREAK);
          evt_d    = '{make: 1'b1, code: {1'b1, bus.rx_data}};
        end
        BRK: begin
          evt_fire = (bus.rx_data != PS2_EXTEND) && (bus.rx_data != PS2_BREAK);
          evt_d    = '{make: 1'b0, code: {1'b0, bus.rx_data}};
        end
        EXT_BRK: begin
          evt_fire = (bus.rx_data != PS2_EXTEND) && (bus.rx_data != PS2_BREAK);
          evt_d    = '{make: 1'b0, code: {1'b1, bus.rx_data}};
        end
        default: evt_fire = 1'b0;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign push = evt_fire && !(evt_d.make && key_down[evt_d.code]);
`else
  assign push = evt_fire;
`endif

  assign pop  = !empty && bus.evt_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RESET_STATE;
      key_down <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.rx_valid) begin
        case (state)
          WAIT_INIT: if (bus.rx_data == PS2_BAT_OK) state <= IDLE;
          IDLE: begin
            if (bus.rx_data == PS2_EXTEND)      state    <= EXT;
            else if (bus.rx_data == PS2_BREAK)  state    <= BRK;
            else if (bus.rx_data == PS2_BAT_OK) key_down <= '0;
          end
          EXT:     state <= (bus.rx_data == PS2_BREAK) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
      if (evt_fire) key_down[evt_d.code] <= evt_d.make;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .WIDTH ($bits(ps2_evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (evt_d),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  assign bus.evt_valid = !empty;
  assign bus.evt_code  = head.code;
  assign bus.evt_make  = head.make;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed and randomized check of the PS/2 key event decoder against a flag/queue reference model.
module tb_ps2_key_event_decoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst;
  logic [511:0]   key_down;
  logic [LW-1:0]  fifo_level;
  logic           overflow;
  logic           clr_overflow;

  ps2_key_event_decoder_if bus();

  ps2_key_event_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .INIT_REQUIRED (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .key_down     (key_down),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit           m_init;
  bit           m_ext;
  bit           m_brk;
  logic [511:0] m_keys;
  logic [9:0]   m_q[$];
  bit           m_ovf;

  logic [7:0] pool   [8] = '{8'h1C, 8'h75, 8'h12, 8'h5A, 8'h29, 8'h6B, 8'h1A, 8'h22};
  logic [7:0] ignore [6] = '{8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1};

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_keys = '0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  function automatic bit is_ignored(input logic [7:0] b);
    foreach (ignore[i]) if (ignore[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    bit         fire = 1'b0;
    logic [9:0] ev   = '0;
    bit         pop  = rdy && (m_q.size() != 0);
    bit         q_it;
    bit         dropped = 1'b0;
    if (v) begin
      if (!m_init) begin
        if (b == 8'hAA) m_init = 1'b1;
      end else if (!m_ext && !m_brk) begin
        if (b == 8'hE0)        m_ext  = 1'b1;
        else if (b == 8'hF0)   m_brk  = 1'b1;
        else if (b == 8'hAA)   m_keys = '0;
        else if (!is_ignored(b)) begin
          fire = 1'b1;
          ev   = {1'b1, 1'b0, b};
        end
      end else begin
        if (b == 8'hE0 || (b == 8'hF0 && m_brk)) begin
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else if (b == 8'hF0) begin
          m_brk = 1'b1;
        end else begin
          fire  = 1'b1;
          ev    = {!m_brk, m_ext, b};
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
    end
    q_it = fire;
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (fire && ev[9] && m_keys[ev[8:0]]) q_it = 1'b0;
`endif
    if (fire) m_keys[ev[8:0]] = ev[9];
    if (pop) void'(m_q.pop_front());
    if (q_it) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else dropped = 1'b1;
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    logic [9:0] h = (m_q.size() != 0) ? m_q[0] : 10'h000;
    check({tag, "_evt"}, {bus.evt_valid, bus.evt_make, bus.evt_code}, {m_q.size() != 0, h});
    check({tag, "_lvl_ovf"}, {fifo_level, overflow}, {LW'(m_q.size()), m_ovf});
    check({tag, "_keys"}, key_down, m_keys);
  endtask

  task automatic cycle(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
    bus.rx_valid  = v;
    bus.rx_data   = b;
    bus.evt_ready = rdy;
    clr_overflow  = clr;
    @(posedge clk);
    model_step(v, b, rdy, clr);
    #1;
    compare_all("cyc");
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_zero", {key_down, fifo_level, overflow, bus.evt_valid, bus.evt_code, bus.evt_make}, '0);
    compare_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r = $urandom_range(0, 99);
    if (r < 15) return 8'hE0;
    if (r < 30) return 8'hF0;
    if (r < 34) return 8'hAA;
    if (r < 42) return ignore[$urandom_range(0, 5)];
    if (r < 47) return 8'($urandom);
    return pool[$urandom_range(0, 7)];
  endfunction

  initial begin
    rst           = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.evt_ready = 1'b0;
    clr_overflow  = 1'b0;
    #1;
    do_reset();

    // Bytes before self-test are ignored; afterwards a plain make is queued
    send(8'h1C);
    check("pre_init_no_evt", bus.evt_valid, 1'b0);
    send(8'hAA);
    send(8'h1C);
    check("init_make_1c", {bus.evt_valid, bus.evt_make, bus.evt_code}, {1'b1, 1'b1, 9'h01C});
    check("init_key_1c", key_down[9'h01C], 1'b1);
    drain();

    // Extended make then extended break
    send(8'hE0); send(8'h75);
    check("ext_make_175", {bus.evt_make, bus.evt_code}, {1'b1, 9'h175});
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_lvl", fifo_level, LW'(2));
    check("ext_key_175", key_down[9'h175], 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("ext_break_175", {bus.evt_valid, bus.evt_make, bus.evt_code}, {1'b1, 1'b0, 9'h175});
    drain();

    // Auto-repeat handling
    send(8'hF0); send(8'h1C);
    drain();
    send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("repeat_lvl", fifo_level, LW'(1));
`else
    check("repeat_lvl", fifo_level, LW'(3));
`endif
    drain();

    // Overflow with a stalled consumer
    send(8'h12); send(8'h5A); send(8'h29); send(8'h6B); send(8'h1A);
    check("ovf_lvl", {fifo_level, overflow}, {LW'(4), 1'b1});
    check("ovf_key_1a", key_down[9'h01A], 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", overflow, 1'b0);

    // Push and pop together on a full queue
    cycle(1'b1, 8'h22, 1'b1, 1'b0);
    check("full_pushpop", {fifo_level, bus.evt_code}, {LW'(4), 9'h05A});

    // Reset discards a pending prefix and the queue
    send(8'hE0);
    do_reset();
    send(8'hAA); send(8'h75);
    check("post_rst_make_075", {bus.evt_valid, bus.evt_make, bus.evt_code}, {1'b1, 1'b1, 9'h075});

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 7, rand_byte(), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
